pp_accumulator: RTL

//  Sequential consumer of the nbitshift partial-product array: one shifted multiplicand (D<<i) per cycle,

---
 rtl/pp_accumulator_pkg.sv | 19 +
 rtl/pp_accumulator_if.sv | 25 ++
 rtl/pp_accumulator_select_add.sv | 23 ++
 rtl/pp_accumulator.sv | 113 +++++++++++
 4 files changed

// File: rtl/pp_accumulator_pkg.sv
// Shared types for the shift-add partial-product accumulator.
// Optional macro PP_ACCUMULATOR_EARLY_TERM_EN is consumed by pp_accumulator, not here.
package pp_acc_pkg;

  localparam int PP_N = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } pp_acc_state_t;

  typedef logic [PP_N-1:0][PP_N-1:0] pp_array_t;

  function automatic int idx_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/pp_accumulator_if.sv
// Operand/result handshake bundle between the partial-product source, the accumulator and the result consumer.
interface pp_accumulator_if #(
  parameter int N = 16
);

  logic                  in_valid;
  logic                  in_ready;
  logic [N-1:0][N-1:0]   pp;
  logic [N-1:0]          mult;
  logic                  out_valid;
  logic                  out_ready;
  logic [N-1:0]          product;
  logic                  busy;

  modport master (
    output in_valid, pp, mult, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, pp, mult, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/pp_accumulator_select_add.sv
// Combinational step of the accumulator: adds the indexed partial product when its multiplier bit is set.
module pp_select_add #(
  parameter int N     = 16,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]          acc,
  input  logic [N-1:0][N-1:0]   pp_r,
  input  logic [N-1:0]          mult_r,
  input  logic [IDX_W-1:0]      idx,
  output logic [N-1:0]          sum
);

  // Carry out of bit N-1 is intentionally dropped: result is the product mod 2^N.
  always_comb begin
    sum = acc;
    if (mult_r[idx]) begin
      sum = acc + pp_r[idx];
    end else begin
      sum = acc;
    end
  end

endmodule

// File: rtl/pp_accumulator.sv
// Sequential shift-add accumulator: one partial product per cycle into an N-bit running product.
// Define PP_ACCUMULATOR_EARLY_TERM_EN to stop once no higher multiplier bits remain.
module pp_accumulator
  import pp_acc_pkg::*;
#(
  parameter int N = PP_N
) (
  input  logic                 clk,
  input  logic                 rst,
  pp_accumulator_if.slave      bus
);

  localparam int IDX_W = idx_width(N);

  pp_acc_state_t         state;
  logic [N-1:0][N-1:0]   pp_r;
  logic [N-1:0]          mult_r;
  logic [N-1:0]          acc;
  logic [IDX_W-1:0]      idx;
  logic                  out_valid;
  logic [N-1:0]          product;
  logic [N-1:0]          sum;
  logic                  last_step;

  pp_select_add #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_select_add (
    .acc    (acc),
    .pp_r   (pp_r),
    .mult_r (mult_r),
    .idx    (idx),
    .sum    (sum)
  );

  // Decide whether the current ACCUM edge is the final one.
  always_comb begin
    last_step = 1'b0;
`ifdef PP_ACCUMULATOR_EARLY_TERM_EN
    if ((idx == IDX_W'(N - 1)) || ((mult_r >> (32'(idx) + 32'd1)) == '0)) begin
      last_step = 1'b1;
    end else begin
      last_step = 1'b0;
    end
`else
    if (idx == IDX_W'(N - 1)) begin
      last_step = 1'b1;
    end else begin
      last_step = 1'b0;
    end
`endif
  end

  // Control FSM, operand snapshot, index counter and registered result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pp_r      <= '0;
      mult_r    <= '0;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      product   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            pp_r   <= bus.pp;
            mult_r <= bus.mult;
            acc    <= '0;
            idx    <= '0;
`ifdef PP_ACCUMULATOR_EARLY_TERM_EN
            if (bus.mult == '0) begin
              state     <= DONE;
              product   <= '0;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
`else
            state <= ACCUM;
`endif
          end
        end
        ACCUM: begin
          acc <= sum;
          idx <= idx + IDX_W'(1);
          if (last_step) begin
            state     <= DONE;
            product   <= sum;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == ACCUM) || (state == DONE);
  assign bus.out_valid = out_valid;
  assign bus.product   = product;

endmodule
